// File: rtl/ahb_lite_sram_ws.sv
// AHB-lite subordinate SRAM with configurable width/depth, programmable wait states,
// ERROR responses for illegal transfers and read-after-write forwarding.
module ahb_lite_sram_ws #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 14,
  parameter int WAIT_STATES   = 0,
  parameter int ERR_UNALIGNED = 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int         BYTES    = DATA_W / 8;
  localparam int         OFF_W    = $clog2(BYTES);
  localparam int         IDX_W    = ADDR_W - OFF_W;
  localparam int         DEPTH    = 1 << IDX_W;
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);
  localparam logic [2:0] WS       = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  // Byte lanes covered by a transfer of 2^size bytes starting at lane off.
  function automatic logic [BYTES-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                 input logic [2:0]       size);
    logic [BYTES-1:0] m;
    int               span;
    span = 1 << size;
    m    = '0;
    for (int k = 0; k < BYTES; k++) begin
      m[k] = (k >= int'(off)) && (k < int'(off) + span);
    end
    return m;
  endfunction

  // Offset bits that must be zero for a transfer of 2^size bytes.
  function automatic logic [OFF_W-1:0] size_mask(input logic [2:0] size);
    logic [OFF_W-1:0] m;
    for (int k = 0; k < OFF_W; k++) begin
      m[k] = (k < int'(size));
    end
    return m;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q,  state_d;
  logic [2:0]        cnt_q,    cnt_d;
  logic              hready_q, hready_d;
  logic              hresp_q,  hresp_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [IDX_W-1:0]  dp_idx_q,   dp_idx_d;
  logic [BYTES-1:0]  dp_be_q,    dp_be_d;

  logic              accept;
  logic              illegal;
  logic              commit;
  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  smask;
  logic [IDX_W-1:0]  idx;
  logic [BYTES-1:0]  be;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_fwd;

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign off     = HADDR[OFF_W-1:0];
  assign smask   = size_mask(HSIZE);
  assign illegal = (HSIZE > MAX_SIZE) | ((ERR_UNALIGNED != 0) & (|(off & smask)));
  assign idx     = HADDR[ADDR_W-1:OFF_W];
  // With ERR_UNALIGNED=0 the sub-size offset bits are simply dropped.
  assign be      = lane_mask(off & ~smask, HSIZE);
  assign commit  = dp_valid_q & dp_write_q & hready_q & ~hresp_q;
  assign rd_word = mem[idx];

  // Read data with lanes being written on this same edge taken from HWDATA.
  always_comb begin
    rd_fwd = rd_word;
    for (int b = 0; b < BYTES; b++) begin
      if (commit && (dp_idx_q == idx) && dp_be_q[b]) begin
        rd_fwd[8*b +: 8] = HWDATA[8*b +: 8];
      end else begin
        rd_fwd[8*b +: 8] = rd_word[8*b +: 8];
      end
    end
  end

  // Response FSM, wait counter and data-phase capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hready_d   = hready_q;
    hresp_d    = hresp_q;
    hrdata_d   = hrdata_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_be_d    = dp_be_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d    = S_IDLE;
        hready_d   = 1'b1;
        hresp_d    = 1'b0;
        dp_valid_d = 1'b0;
        if (accept) begin
          if (illegal) begin
            state_d  = S_ERR1;
            hready_d = 1'b0;
            hresp_d  = 1'b1;
          end else begin
            dp_valid_d = 1'b1;
            dp_write_d = HWRITE;
            dp_idx_d   = idx;
            dp_be_d    = be;
            if (!HWRITE) begin
              hrdata_d = rd_fwd;
            end else begin
              hrdata_d = hrdata_q;
            end
            if (WAIT_STATES > 0) begin
              state_d  = S_WAIT;
              cnt_d    = WS;
              hready_d = 1'b0;
            end else begin
              state_d  = S_IDLE;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d  = S_IDLE;
          cnt_d    = 3'd0;
          hready_d = 1'b1;
          hresp_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1: begin
        state_d  = S_ERR2;
        hready_d = 1'b1;
        hresp_d  = 1'b1;
      end
      default: begin
        state_d    = S_IDLE;
        cnt_d      = 3'd0;
        hready_d   = 1'b1;
        hresp_d    = 1'b0;
        dp_valid_d = 1'b0;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      hready_q   <= 1'b1;
      hresp_q    <= 1'b0;
      hrdata_q   <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      hrdata_q   <= hrdata_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      dp_be_q    <= dp_be_d;
    end
  end

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (dp_be_q[b]) begin
          mem[dp_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_lite_sram_ws.sv
// Directed bench for ahb_lite_sram_ws: four instances (32b/0ws, 32b/3ws, 64b/0ws, 32b/5ws)
// share one address/data bus, each selected by its own HSEL bit.
module tb_ahb_lite_sram_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst5_n;
  logic [3:0]  hsel;
  logic [13:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;

  logic        rdy0, rdy3, rdy64, rdy5;
  logic        resp0, resp3, resp64, resp5;
  logic [31:0] rdata0, rdata3, rdata5;
  logic [63:0] rdata64;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ahb_lite_sram_ws #(.DATA_W(32), .ADDR_W(14), .WAIT_STATES(0), .ERR_UNALIGNED(1)) u0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HREADY(rdy0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata[31:0]),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0));

  ahb_lite_sram_ws #(.DATA_W(32), .ADDR_W(14), .WAIT_STATES(3), .ERR_UNALIGNED(1)) u3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HREADY(rdy3), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata[31:0]),
    .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3));

  ahb_lite_sram_ws #(.DATA_W(64), .ADDR_W(14), .WAIT_STATES(0), .ERR_UNALIGNED(1)) u64 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[2]), .HREADY(rdy64), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HREADYOUT(rdy64), .HRESP(resp64), .HRDATA(rdata64));

  ahb_lite_sram_ws #(.DATA_W(32), .ADDR_W(14), .WAIT_STATES(5), .ERR_UNALIGNED(1)) u5 (
    .HCLK(clk), .HRESETn(rst5_n), .HSEL(hsel[3]), .HREADY(rdy5), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata[31:0]),
    .HREADYOUT(rdy5), .HRESP(resp5), .HRDATA(rdata5));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic [3:0] s, input logic [13:0] a, input logic w, input logic [2:0] sz);
    hsel   = s;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = 2'b10;
  endtask

  task automatic idle();
    hsel   = 4'b0000;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst5_n = 1'b0;
    idle();
    haddr  = 14'h0;
    hsize  = 3'd0;
    hwdata = 64'h0;
    #12;
    chk("rst rdy0", {63'd0, rdy0}, 64'd1);
    chk("rst resp0", {63'd0, resp0}, 64'd0);
    chk("rst rdata0", {32'd0, rdata0}, 64'd0);
    chk("rst rdy3", {63'd0, rdy3}, 64'd1);
    chk("rst rdata64", rdata64, 64'd0);
    rst_n  = 1'b1;
    rst5_n = 1'b1;
    cyc();

    // Word write then separate read, zero wait.
    ap(4'b0001, 14'h10, 1'b1, 3'd2); cyc();
    hwdata = 64'hDEADBEEF; idle();
    chk("c1 wr rdy", {63'd0, rdy0}, 64'd1);
    cyc();
    ap(4'b0001, 14'h10, 1'b0, 3'd2); cyc(); idle();
    chk("c1 rd data", {32'd0, rdata0}, 64'hDEADBEEF);
    chk("c1 rd rdy", {63'd0, rdy0}, 64'd1);

    // Byte and halfword partial writes.
    ap(4'b0001, 14'h13, 1'b1, 3'd0); cyc();
    hwdata = 64'hAA000000; idle(); cyc();
    ap(4'b0001, 14'h10, 1'b0, 3'd2); cyc(); idle();
    chk("c2 byte", {32'd0, rdata0}, 64'hAAADBEEF);
    ap(4'b0001, 14'h12, 1'b1, 3'd1); cyc();
    hwdata = 64'h12340000; idle(); cyc();
    ap(4'b0001, 14'h10, 1'b0, 3'd2); cyc(); idle();
    chk("c2 half", {32'd0, rdata0}, 64'h1234BEEF);

    // A write must leave HRDATA untouched.
    ap(4'b0001, 14'h30, 1'b1, 3'd2); cyc();
    hwdata = 64'h77777777; idle(); cyc();
    chk("hold on wr", {32'd0, rdata0}, 64'h1234BEEF);

    // Pipelined write->read forwarding, full and partial.
    ap(4'b0001, 14'h20, 1'b1, 3'd2); cyc();
    hwdata = 64'h11223344;
    ap(4'b0001, 14'h20, 1'b0, 3'd2); cyc(); idle();
    chk("c3 fwd full", {32'd0, rdata0}, 64'h11223344);
    ap(4'b0001, 14'h21, 1'b1, 3'd0); cyc();
    hwdata = 64'h00005500;
    ap(4'b0001, 14'h20, 1'b0, 3'd2); cyc(); idle();
    chk("c3 fwd part", {32'd0, rdata0}, 64'h11225544);
    ap(4'b0001, 14'h20, 1'b0, 3'd2); cyc(); idle();
    chk("c3 mem", {32'd0, rdata0}, 64'h11225544);

    // BUSY transfer: no action.
    hsel = 4'b0001; htrans = 2'b01; haddr = 14'h30; hwrite = 1'b0; hsize = 3'd2;
    cyc(); idle();
    chk("busy data", {32'd0, rdata0}, 64'h11225544);
    chk("busy rdy", {63'd0, rdy0}, 64'd1);

    // Unaligned word write -> two-cycle ERROR, no memory change.
    ap(4'b0001, 14'h11, 1'b1, 3'd2); cyc();
    hwdata = 64'hFFFFFFFF; idle();
    chk("c5 e1 rdy", {63'd0, rdy0}, 64'd0);
    chk("c5 e1 resp", {63'd0, resp0}, 64'd1);
    cyc();
    chk("c5 e2 rdy", {63'd0, rdy0}, 64'd1);
    chk("c5 e2 resp", {63'd0, resp0}, 64'd1);
    cyc();
    chk("c5 after resp", {63'd0, resp0}, 64'd0);
    ap(4'b0001, 14'h10, 1'b0, 3'd2); cyc(); idle();
    chk("c5 mem kept", {32'd0, rdata0}, 64'h1234BEEF);

    // HSIZE=3 on 32-bit bus -> ERROR, HRDATA unchanged.
    ap(4'b0001, 14'h10, 1'b0, 3'd3); cyc(); idle();
    chk("c5 sz e1 rdy", {63'd0, rdy0}, 64'd0);
    chk("c5 sz e1 resp", {63'd0, resp0}, 64'd1);
    chk("c5 sz rdata", {32'd0, rdata0}, 64'h1234BEEF);
    cyc();
    chk("c5 sz e2 resp", {63'd0, resp0}, 64'd1);
    cyc();

    // 64-bit instance: dword write/read.
    ap(4'b0100, 14'h08, 1'b1, 3'd3); cyc();
    hwdata = 64'h0123456789ABCDEF; idle();
    chk("c5 64 resp", {63'd0, resp64}, 64'd0);
    chk("c5 64 rdy", {63'd0, rdy64}, 64'd1);
    cyc();
    ap(4'b0100, 14'h08, 1'b0, 3'd3); cyc(); idle();
    chk("c5 64 rd", rdata64, 64'h0123456789ABCDEF);
    ap(4'b0100, 14'h0C, 1'b0, 3'd2); cyc(); idle();
    chk("c5 64 word rd", rdata64, 64'h0123456789ABCDEF);

    // Three wait states: HWDATA only sampled at the final edge.
    ap(4'b0010, 14'h10, 1'b1, 3'd2); cyc(); idle();
    hwdata = 64'h0BADBAD0;
    chk("c4 w1", {63'd0, rdy3}, 64'd0);
    cyc(); hwdata = 64'hDEAD0001;
    chk("c4 w2", {63'd0, rdy3}, 64'd0);
    cyc(); hwdata = 64'h13572468;
    chk("c4 w3", {63'd0, rdy3}, 64'd0);
    cyc(); hwdata = 64'hCAFEF00D;
    chk("c4 wr ready", {63'd0, rdy3}, 64'd1);
    cyc(); hwdata = 64'hBAADF00D;
    ap(4'b0010, 14'h10, 1'b0, 3'd2); cyc(); idle();
    chk("c4 r1", {63'd0, rdy3}, 64'd0);
    cyc();
    chk("c4 r2", {63'd0, rdy3}, 64'd0);
    cyc();
    chk("c4 r3", {63'd0, rdy3}, 64'd0);
    cyc();
    chk("c4 rd ready", {63'd0, rdy3}, 64'd1);
    chk("c4 rd data", {32'd0, rdata3}, 64'hCAFEF00D);
    chk("c4 resp", {63'd0, resp3}, 64'd0);

    // Five wait states: reset during the second wait cycle.
    ap(4'b1000, 14'h40, 1'b1, 3'd2); cyc(); idle();
    hwdata = 64'h5A5A5A5A;
    chk("c6 wr wait", {63'd0, rdy5}, 64'd0);
    repeat (5) cyc();
    chk("c6 wr ready", {63'd0, rdy5}, 64'd1);
    cyc();
    ap(4'b1000, 14'h40, 1'b0, 3'd2); cyc(); idle();
    repeat (5) cyc();
    chk("c6 rd", {32'd0, rdata5}, 64'h5A5A5A5A);
    ap(4'b1000, 14'h40, 1'b1, 3'd2); cyc(); idle();
    hwdata = 64'hFFFFFFFF;
    cyc();
    chk("c6 mid wait", {63'd0, rdy5}, 64'd0);
    rst5_n = 1'b0;
    #1;
    chk("c6 rst rdy", {63'd0, rdy5}, 64'd1);
    chk("c6 rst resp", {63'd0, resp5}, 64'd0);
    chk("c6 rst rdata", {32'd0, rdata5}, 64'd0);
    cyc();
    rst5_n = 1'b1;
    cyc();
    ap(4'b1000, 14'h40, 1'b0, 3'd2); cyc(); idle();
    repeat (5) cyc();
    chk("c6 after rdy", {63'd0, rdy5}, 64'd1);
    chk("c6 word kept", {32'd0, rdata5}, 64'h5A5A5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_ws.md
Name: ahb_lite_sram_ws

Overview:
- Parametrised AHB-lite subordinate SRAM, successor of the fixed 32-bit zero-wait AHB memory.
- Adds configurable data width and depth, programmable wait states, and ERROR responses for illegal transfers.
- Adds read-after-write forwarding.
- Sits behind the AHB-lite interconnect as a system/boot RAM; single port; no bursts-specific logic (HBURST ignored).

Parameters:
- DATA_W, 32, bus/word width in bits; legal values 32 or 64.
- ADDR_W, 14, byte-address width; memory size = 2^ADDR_W bytes = 2^ADDR_W/(DATA_W/8) words.
- WAIT_STATES, 0, data-phase wait cycles inserted on every OKAY transfer (read or write); legal 0..7.
- ERR_UNALIGNED, 1, 1 = unaligned transfers get ERROR response; 0 = HADDR low bits below HSIZE are ignored (address force-aligned).

Ports:
- HCLK  in  1  clock, rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  subordinate select
- HREADY  in  1  bus ready; address phase sampled only when high
- HADDR  in  ADDR_W  byte address
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) = active
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, 0=byte .. 3=dword
- HWDATA  in  DATA_W  write data, valid in data phase
- HREADYOUT  out  1  subordinate ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_W  read data, registered

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0; FSM=IDLE; wait counter=0; captured address-phase registers cleared. Memory contents are not reset.
- Address phase accepted on a rising edge with HSEL&HREADY&HTRANS[1].
  - HSEL=0, IDLE, or BUSY: no data-phase action; response is OKAY with zero wait.
- Illegal transfer:
  - HSIZE > log2(DATA_W/8), or
  - ERR_UNALIGNED=1 and HADDR not aligned to 2^HSIZE.
- Memory write rules:
  - Lane enables are decoded from HSIZE and the low HADDR bits (little-endian): byte lane k is enabled when k lies in [offset, offset+2^HSIZE).
  - The write commits on the edge ending the data phase (HREADYOUT=1, HRESP=0), using HWDATA sampled at that edge.
  - Only enabled lanes change.
- Read rules:
  - Memory is read with the word index from the address phase.
  - HRDATA is registered at the accepting edge and holds until the next accepted read.
  - Non-read transfers leave HRDATA unchanged.
- Read-after-write forwarding:
  - Applies when a read address phase is accepted on the same edge that commits a write to the same word.
  - HRDATA = written lanes from HWDATA; other lanes from memory.
  - Read latency: data valid in the read data phase with no extra cycle.
- FSM states:
  - IDLE → WAIT when an accepted legal transfer occurs and WAIT_STATES>0. Counter loads WAIT_STATES; HREADYOUT=0.
  - IDLE → ERR1 when an accepted illegal transfer occurs: HREADYOUT=0, HRESP=1.
  - WAIT: counter decrements each cycle; HREADYOUT=0 while the counter is nonzero. The cycle the counter reaches 0 asserts HREADYOUT=1 and returns to IDLE (or re-enters WAIT/ERR1 if a new transfer is accepted that edge).
  - ERR1 → ERR2 unconditionally. ERR2 drives HREADYOUT=1, HRESP=1, then handles the next accepted transfer like IDLE.
  - Error takes priority over wait states: an illegal transfer is always exactly 2 cycles.
- Error side effects: no memory write and no HRDATA update on ERROR.
- Back-to-back transfers: a new address phase is accepted only on edges where HREADY=1, i.e. the final data-phase cycle; pipelining is fully supported with WAIT_STATES=0.
- Word index = HADDR[ADDR_W-1:log2(DATA_W/8)]; addresses wrap within 2^ADDR_W (no out-of-range error).
- Reset mid-operation (WAIT or ERR): immediate return to reset values. A pending write is discarded.

Test Plan:
1. DATA_W=32, WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 → HREADYOUT stays 1; HRDATA=0xDEADBEEF in the read data phase.
2. Byte write 0xAA @0x13 after case 1, read @0x10 → 0xAAADBEEF; halfword write 0x1234 @0x12 → 0x1234BEEF.
3. Back-to-back write 0x11223344 @0x20 immediately followed by read @0x20 (pipelined) → forwarded HRDATA=0x11223344. Partial byte write 0x55 @0x21 followed by read → 0x11225544.
4. WAIT_STATES=3: read @0x10 → HREADYOUT low 3 cycles then high with correct data. A write in the same config commits only on the final cycle; HWDATA changed during wait cycles is ignored except at the final edge.
5. ERR_UNALIGNED=1: word write @0x11 → HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; memory @0x10 unchanged. HSIZE=3 on DATA_W=32 → same error. DATA_W=64: HSIZE=3 write/read @0x8 → OKAY, correct 64-bit data.
6. Assert HRESETn low during WAIT (WAIT_STATES=5, cycle 2) → HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the aborted write leaves the target word unchanged on readback.
